// File: rtl/cache_bus_pkg.sv
// Shared definitions for the CPU-side bus master, the cache model and the bench.
// Holds the C1 command encoding, the response code, the field widths of the
// {tag,set,offset} byte address and the beats-per-command helper.
package cache_bus_pkg;

    localparam int TAG_W    = 8;
    localparam int SET_W    = 6;
    localparam int OFFSET_W = 4;
    localparam int ADDR_W   = TAG_W + SET_W + OFFSET_W;
    localparam int A1_W     = TAG_W + SET_W;
    localparam int D1_W     = 16;
    localparam int C1_W     = 3;

    typedef enum logic [C1_W-1:0] {
        C1_NOP   = 3'd0,
        C1_RD8   = 3'd1,
        C1_RD16  = 3'd2,
        C1_RD32  = 3'd3,
        C1_INVAL = 3'd4,
        C1_WR8   = 3'd5,
        C1_WR16  = 3'd6,
        C1_WR32  = 3'd7
    } c1_cmd_e;

    // Code the cache places on C1 for every response beat.
    localparam logic [C1_W-1:0] C1_RESPONSE = 3'd7;

    // A 32-bit read needs two 16-bit D1 beats; everything else completes on one.
    function automatic logic [1:0] beats_for(input c1_cmd_e cmd);
        return (cmd == C1_RD32) ? 2'd2 : 2'd1;
    endfunction

    function automatic logic is_write(input c1_cmd_e cmd);
        return (cmd == C1_WR8) || (cmd == C1_WR16) || (cmd == C1_WR32);
    endfunction

endpackage

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: turns a single-outstanding valid/ready core request into
// the C1/A1/D1 command sequence the cache consumes, then collects the
// cache's response beats (C1 == 7) and reports completion on resp_valid.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         core handshake; ready only while idle
//   req_cmd/req_addr/req_wdata  command, {tag,set,offset} address, write data
//   resp_valid/resp_rdata/resp_err  one-cycle completion pulse, data, timeout
//   a1_out/a1_oe                A1 address bus drive value/enable
//   d1_out/d1_oe/d1_in          D1 data bus drive value/enable, resolved value
//   c1_out/c1_oe/c1_in          C1 command bus drive value/enable, resolved value
//   req_count                   number of accepted requests (wraps)
//
// Bus drive values are decoded from registered state, so the bus is driven
// the cycle after acceptance and released as soon as reset asserts.
module cpu_bus_master
    import cache_bus_pkg::*;
#(
    parameter int ADDR_SIZE      = ADDR_W,
    parameter int TAG_SIZE       = TAG_W,
    parameter int SET_SIZE       = SET_W,
    parameter int OFFSET_SIZE    = OFFSET_W,
    parameter int A1_SIZE        = A1_W,
    parameter int D1_SIZE        = D1_W,
    parameter int C1_SIZE        = C1_W,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [2:0]           req_cmd,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [A1_SIZE-1:0]   a1_out,
    output logic                 a1_oe,
    output logic [D1_SIZE-1:0]   d1_out,
    output logic                 d1_oe,
    input  logic [D1_SIZE-1:0]   d1_in,
    output logic [C1_SIZE-1:0]   c1_out,
    output logic                 c1_oe,
    input  logic [C1_SIZE-1:0]   c1_in,
    output logic [31:0]          req_count
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    // The counter starts at 0 on WAIT entry; the edge that would take it to
    // TIMEOUT_CYCLES-1 is the one that gives up.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD1, S_CMD2, S_TURN, S_WAIT, S_RELEASE
    } state_e;

    state_e                state_reg, state_next;
    c1_cmd_e               cmd_reg, cmd_next;
    logic [ADDR_SIZE-1:0]  addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [TMR_W-1:0]      timer_reg, timer_next;
    logic                  beat_cnt_reg, beat_cnt_next;
    logic [D1_SIZE-1:0]    low_half_reg, low_half_next;
    logic                  resp_valid_reg, resp_valid_next;
    logic                  resp_err_reg, resp_err_next;
    logic [31:0]           resp_rdata_reg, resp_rdata_next;
    logic [31:0]           req_count_reg, req_count_next;

    logic                  beat;
    logic                  final_beat;
    logic                  timeout_hit;
    logic [31:0]           rdata_final;

    // An X/Z on C1 compares unknown and therefore never counts as a beat.
    assign beat        = (c1_in == C1_RESPONSE);
    assign final_beat  = (beats_for(cmd_reg) == 2'd1) || beat_cnt_reg;
    assign timeout_hit = (timer_reg == TMR_LAST);

    // Read data as it stands on the final beat: the current D1 value plus,
    // for RD32, the low half captured on the first beat.
    always_comb begin
        rdata_final = '0;
        case (cmd_reg)
            C1_RD8:  rdata_final = {24'b0, d1_in[7:0]};
            C1_RD16: rdata_final = 32'(d1_in);
            C1_RD32: rdata_final = 32'({d1_in, low_half_reg});
            default: rdata_final = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cmd_reg        <= C1_NOP;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            timer_reg      <= '0;
            beat_cnt_reg   <= 1'b0;
            low_half_reg   <= '0;
            resp_valid_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            resp_rdata_reg <= '0;
            req_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cmd_reg        <= cmd_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            timer_reg      <= timer_next;
            beat_cnt_reg   <= beat_cnt_next;
            low_half_reg   <= low_half_next;
            resp_valid_reg <= resp_valid_next;
            resp_err_reg   <= resp_err_next;
            resp_rdata_reg <= resp_rdata_next;
            req_count_reg  <= req_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cmd_next        = cmd_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        timer_next      = timer_reg;
        beat_cnt_next   = beat_cnt_reg;
        low_half_next   = low_half_reg;
        resp_valid_next = 1'b0;
        resp_err_next   = 1'b0;
        resp_rdata_next = '0;
        req_count_next  = req_count_reg;

        req_ready = 1'b0;
        a1_oe     = 1'b0;
        a1_out    = '0;
        c1_oe     = 1'b0;
        c1_out    = '0;
        d1_oe     = 1'b0;
        d1_out    = '0;

        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cmd_next       = c1_cmd_e'(req_cmd);
                    addr_next      = req_addr;
                    wdata_next     = req_wdata;
                    req_count_next = req_count_reg + 32'd1;
                    // NOP never touches the bus; it completes straight away.
                    if (c1_cmd_e'(req_cmd) == C1_NOP) begin
                        resp_valid_next = 1'b1;
                    end else begin
                        state_next = S_CMD1;
                    end
                end
            end

            S_CMD1: begin
                c1_oe  = 1'b1;
                c1_out = cmd_reg;
                a1_oe  = 1'b1;
                a1_out = {addr_reg[ADDR_SIZE-1 -: TAG_SIZE], addr_reg[OFFSET_SIZE +: SET_SIZE]};
                if (is_write(cmd_reg)) begin
                    d1_oe  = 1'b1;
                    d1_out = (cmd_reg == C1_WR8) ? D1_SIZE'(wdata_reg[7:0])
                                                 : D1_SIZE'(wdata_reg[15:0]);
                end
                state_next = S_CMD2;
            end

            S_CMD2: begin
                c1_oe  = 1'b1;
                c1_out = cmd_reg;
                a1_oe  = 1'b1;
                a1_out = A1_SIZE'(addr_reg[OFFSET_SIZE-1:0]);
                // Only WR32 has a second data half to send.
                if (cmd_reg == C1_WR32) begin
                    d1_oe  = 1'b1;
                    d1_out = D1_SIZE'(wdata_reg[31:16]);
                end
                state_next = S_TURN;
            end

            S_TURN: begin
                timer_next    = '0;
                beat_cnt_next = 1'b0;
                state_next    = S_WAIT;
            end

            S_WAIT: begin
                if (beat) begin
                    timer_next = '0;
                    if (final_beat) begin
                        resp_valid_next = 1'b1;
                        resp_rdata_next = rdata_final;
                        state_next      = S_RELEASE;
                    end else begin
                        low_half_next = d1_in;
                        beat_cnt_next = 1'b1;
                    end
                end else if (timeout_hit) begin
                    resp_valid_next = 1'b1;
                    resp_err_next   = 1'b1;
                    state_next      = S_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            S_RELEASE: begin
                // Wait for the cache to drop its response so a held C1 == 7
                // cannot be counted as a beat of the next request. A stuck
                // response is abandoned silently: completion was already sent.
                if (!beat || timeout_hit) begin
                    state_next = S_IDLE;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign resp_valid = resp_valid_reg;
    assign resp_err   = resp_err_reg;
    assign resp_rdata = resp_rdata_reg;
    assign req_count  = req_count_reg;

endmodule

// File: tb/tb_cpu_bus_master.sv
// Self-checking bench for cpu_bus_master. The bench plays the cache on
// C1/D1 and predicts every bus value, read result and latency from the
// command rules directly (byte/half-word arithmetic and beat counts).
module tb_cpu_bus_master;

    localparam int TIMEOUT = 512;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_cmd;
    logic [17:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [13:0] a1_out;
    logic        a1_oe;
    logic [15:0] d1_out;
    logic        d1_oe;
    logic [15:0] d1_in;
    logic [2:0]  c1_out;
    logic        c1_oe;
    logic [2:0]  c1_in;
    logic [31:0] req_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    int txn_no = 0;

    cpu_bus_master #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .a1_out     (a1_out),
        .a1_oe      (a1_oe),
        .d1_out     (d1_out),
        .d1_oe      (d1_oe),
        .d1_in      (d1_in),
        .c1_out     (c1_out),
        .c1_oe      (c1_oe),
        .c1_in      (c1_in),
        .req_count  (req_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, "_c1_oe"}, 32'(c1_oe), 32'd0);
        check({tag, "_a1_oe"}, 32'(a1_oe), 32'd0);
        check({tag, "_d1_oe"}, 32'(d1_oe), 32'd0);
    endtask

    // Full request with the bench acting as the cache: d0 idle WAIT edges
    // before the first beat, g idle edges between RD32 beats, and the final
    // response held for `hold` extra edges.
    task automatic do_txn(input logic [2:0] cmd, input logic [17:0] addr, input logic [31:0] wdata,
                          input int d0, input int g, input int hold,
                          input logic [15:0] data0, input logic [15:0] data1);
        bit          wr;
        int          beats;
        int          cyc;
        int          exp_lat;
        logic [31:0] exp_rdata;

        wr    = (cmd >= 3'd5);
        beats = (cmd == 3'd3) ? 2 : 1;
        case (cmd)
            3'd1:    exp_rdata = 32'(data0) & 32'h0000_00FF;
            3'd2:    exp_rdata = 32'(data0);
            3'd3:    exp_rdata = (32'(data1) << 16) | 32'(data0);
            default: exp_rdata = 32'd0;
        endcase
        exp_lat = 4 + d0 + ((beats == 2) ? g + 1 : 0);

        check("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_cmd   = 3'd0;
        exp_count++;
        txn_no++;
        check("req_count", req_count, 32'(exp_count));

        if (cmd == 3'd0) begin
            check("nop_resp_valid", 32'(resp_valid), 32'd1);
            check("nop_rdata", resp_rdata, 32'd0);
            check("nop_err", 32'(resp_err), 32'd0);
            check("nop_ready", 32'(req_ready), 32'd1);
            check_bus_idle("nop");
            $display("txn %0d cmd=%0d addr=%h rdata=%h err=%b", txn_no, cmd, addr, resp_rdata, resp_err);
            return;
        end

        // First command cycle: full command, {tag,set}, low write half.
        check("cmd1_ready", 32'(req_ready), 32'd0);
        check("cmd1_c1_oe", 32'(c1_oe), 32'd1);
        check("cmd1_c1", 32'(c1_out), 32'(cmd));
        check("cmd1_a1_oe", 32'(a1_oe), 32'd1);
        check("cmd1_a1", 32'(a1_out), 32'(addr) >> 4);
        check("cmd1_d1_oe", 32'(d1_oe), 32'(wr));
        if (wr)
            check("cmd1_d1", 32'(d1_out), (cmd == 3'd5) ? (wdata & 32'hFF) : (wdata & 32'hFFFF));
        step();

        // Second command cycle: offset only, high write half for WR32.
        check("cmd2_c1_oe", 32'(c1_oe), 32'd1);
        check("cmd2_c1", 32'(c1_out), 32'(cmd));
        check("cmd2_a1_oe", 32'(a1_oe), 32'd1);
        check("cmd2_a1", 32'(a1_out), 32'(addr) & 32'hF);
        check("cmd2_d1_oe", 32'(d1_oe), (cmd == 3'd7) ? 32'd1 : 32'd0);
        if (cmd == 3'd7)
            check("cmd2_d1", 32'(d1_out), wdata >> 16);
        step();

        check_bus_idle("turn");
        c1_in = 3'd0;
        step();
        cyc = 3;

        repeat (d0) begin
            step();
            cyc++;
            check("wait_no_resp", 32'(resp_valid), 32'd0);
        end
        c1_in = 3'd7;
        d1_in = data0;
        step();
        cyc++;
        if (beats == 2) begin
            c1_in = 3'd0;
            d1_in = 16'($urandom);
            repeat (g) begin
                step();
                cyc++;
                check("gap_no_resp", 32'(resp_valid), 32'd0);
            end
            c1_in = 3'd7;
            d1_in = data1;
            step();
            cyc++;
        end

        check("resp_valid", 32'(resp_valid), 32'd1);
        check("resp_err", 32'(resp_err), 32'd0);
        check("resp_rdata", resp_rdata, exp_rdata);
        check("latency", 32'(cyc), 32'(exp_lat));
        $display("txn %0d cmd=%0d addr=%h rdata=%h err=%b lat=%0d", txn_no, cmd, addr, resp_rdata, resp_err, cyc);

        d1_in = 16'($urandom);
        repeat (hold) begin
            step();
            check("hold_no_resp", 32'(resp_valid), 32'd0);
            check("hold_not_ready", 32'(req_ready), 32'd0);
        end
        c1_in = 3'd0;
        step();
        check("release_no_resp", 32'(resp_valid), 32'd0);
        check("release_ready", 32'(req_ready), 32'd1);
    endtask

    // Request that the cache never answers.
    task automatic do_timeout(input logic [2:0] cmd, input logic [17:0] addr);
        int cyc;
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        step();
        req_valid = 1'b0;
        exp_count++;
        txn_no++;
        c1_in = 3'd0;
        cyc = 0;
        for (int k = 0; k < TIMEOUT + 64 && !resp_valid; k++) begin
            if (k > 0) step();
            if (k > 0) cyc++;
        end
        // The loop above steps until resp_valid; count edges since acceptance.
        cyc = cyc + 0;
        check("to_latency", 32'(cyc), 32'(TIMEOUT + 2));
        check("to_valid", 32'(resp_valid), 32'd1);
        check("to_err", 32'(resp_err), 32'd1);
        check("to_rdata", resp_rdata, 32'd0);
        check("to_ready", 32'(req_ready), 32'd1);
        $display("txn %0d cmd=%0d addr=%h rdata=%h err=%b lat=%0d", txn_no, cmd, addr, resp_rdata, resp_err, cyc);
        step();
        check("to_pulse_end", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 3'd0;
        req_addr  = '0;
        req_wdata = '0;
        c1_in     = 3'd0;
        d1_in     = '0;

        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_err", 32'(resp_err), 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_count", req_count, 32'd0);
        check_bus_idle("rst");
        check("rst_outs", {15'd0, a1_out, c1_out}, 32'd0);
        check("rst_d1_out", 32'(d1_out), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Directed cases.
        do_txn(3'd2, 18'h0ABC5, 32'h0, 0, 0, 0, 16'hBEEF, 16'h0);
        do_txn(3'd7, 18'h2F00A, 32'h1234_5678, 0, 0, 0, 16'h0, 16'h0);
        do_txn(3'd3, 18'h13579, 32'h0, 0, 3, 4, 16'h1111, 16'h2222);
        do_txn(3'd5, 18'h00003, 32'hA5A5_A5C3, 1, 0, 1, 16'h0, 16'h0);
        do_timeout(3'd1, 18'h3FFFF);

        // Reset while the command is on the bus: bus must drop at once.
        req_valid = 1'b1;
        req_cmd   = 3'd2;
        req_addr  = 18'h01234;
        step();
        req_valid = 1'b0;
        check("pre_rst_c1_oe", 32'(c1_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_bus_idle("rst_cmd1");
        check("rst_cmd1_count", req_count, 32'd0);
        step();
        rst_n = 1'b1;
        exp_count = 0;

        // Reset while waiting for the response: no completion may follow.
        req_valid = 1'b1;
        req_cmd   = 3'd1;
        req_addr  = 18'h04444;
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check_bus_idle("rst_wait");
        check("rst_wait_valid", 32'(resp_valid), 32'd0);
        check("rst_wait_count", req_count, 32'd0);
        check("rst_wait_ready", 32'(req_ready), 32'd1);
        c1_in = 3'd7;
        step();
        check("rst_wait_no_resp", 32'(resp_valid), 32'd0);
        c1_in = 3'd0;
        rst_n = 1'b1;
        exp_count = 0;
        step();

        do_txn(3'd1, 18'h0ABC5, 32'h0, 0, 0, 0, 16'h77C3, 16'h0);
        exp_count = 1;
        // Back-to-back NOP then INVAL.
        do_txn(3'd0, 18'h12345, 32'h0, 0, 0, 0, 16'h0, 16'h0);
        do_txn(3'd4, 18'h1234A, 32'h0, 0, 0, 0, 16'h0, 16'h0);
        check("b2b_count", req_count, 32'd3);

        // Randomized traffic.
        for (int n = 0; n < 24; n++) begin
            do_txn(3'($urandom_range(0, 7)), 18'($urandom), $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   16'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Upstream CPU-side stage of the cache: converts a simple valid/ready request interface into the C1/A1/D1 command bus protocol the cache consumes.
- Per request: drives the command and split address, drives write data, turns the bus around, then collects the cache's response beats (C1 = 7).
- Reports completion and read data on a one-cycle response pulse, with a timeout guard so the core never hangs on a dead bus.
- Bidirectional buses are split into out/oe/in port triples; tristate resolution lives at the top level.

Parameters:
ADDR_SIZE, 18, full byte address width (tag 8 + set 6 + offset 4)
TAG_SIZE, 8, tag field width
SET_SIZE, 6, set field width
OFFSET_SIZE, 4, offset field width
A1_SIZE, 14, A1 bus width (TAG_SIZE+SET_SIZE)
D1_SIZE, 16, D1 bus width
C1_SIZE, 3, C1 bus width
TIMEOUT_CYCLES, 512, max cycles between beats before error completion

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  core request valid
req_ready  out  1  high only in IDLE
req_cmd  in  3  C1 command code (0 NOP, 1 RD8, 2 RD16, 3 RD32, 4 INVAL, 5 WR8, 6 WR16, 7 WR32)
req_addr  in  ADDR_SIZE  byte address {tag,set,offset}
req_wdata  in  32  write data, little-endian
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  read data, zero-extended; 0 for writes/inval/error
resp_err  out  1  qualifies resp_valid: timeout
a1_out  out  A1_SIZE  A1 drive value
a1_oe  out  1  A1 drive enable
d1_out  out  D1_SIZE  D1 drive value
d1_oe  out  1  D1 drive enable
d1_in  in  D1_SIZE  resolved D1
c1_out  out  C1_SIZE  C1 drive value
c1_oe  out  1  C1 drive enable
c1_in  in  C1_SIZE  resolved C1
req_count  out  32  accepted requests, wraps

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; all *_oe=0, *_out=0; req_count=0.
- Reset mid-transaction: bus released immediately, request dropped, no resp_valid.
- States: IDLE, CMD1, CMD2, TURN, WAIT, RELEASE.
- IDLE: request accepted on edge with req_valid&&req_ready. Latches cmd/addr/wdata; req_count++.
  - req_cmd=0 (NOP): no bus activity; resp_valid=1, rdata=0 next cycle; stays IDLE.
  - Otherwise go to CMD1.
- CMD1 (1 cycle):
  - c1_oe=a1_oe=1; c1_out=cmd; a1_out={tag,set}.
  - Writes: d1_oe=1, d1_out=wdata[15:0]; WR8 drives only meaningful bits [7:0], upper zero.
- CMD2 (1 cycle):
  - c1_out=cmd; a1_out={{A1_SIZE-OFFSET_SIZE}0, offset}.
  - WR32: d1_out=wdata[31:16]; WR8/WR16: d1_oe=0.
  - INVAL: offset driven, ignored by the cache.
- TURN (1 cycle): all oe=0.
- WAIT:
  - Every edge with c1_in==7 is one beat.
  - Required beats: RD32 = 2; all other commands = 1.
  - Capture: RD8 rdata={24'b0,d1_in[7:0]}; RD16 {16'b0,d1_in}; RD32 beat0 -> [15:0], beat1 -> [31:16].
  - Final beat: resp_valid=1 for the next cycle with assembled rdata; go to RELEASE.
- RELEASE: wait until c1_in!=7 is sampled, then IDLE. Prevents a held response from being counted as a beat of the next request.
- Latency: bus first driven the cycle after acceptance. Minimum acceptance-to-resp_valid with response on the first WAIT edge is 4 cycles (RD32 min 5).
- Timeout: counter cleared on TURN exit and on each beat; runs in WAIT and RELEASE.
  - Reaching TIMEOUT_CYCLES-1 in WAIT: resp_valid=1, resp_err=1, rdata=0, then IDLE.
  - In RELEASE: silently return to IDLE with no second response.
- c1_in X/Z treated as not-response.
- Only one outstanding request; req_ready=0 outside IDLE.

Decomposition:
- Package cache_bus_pkg:
  - c1_cmd_e enum (NOP..WR32);
  - C1_RESPONSE=3'd7;
  - field-width localparams (TAG/SET/OFFSET/A1/D1/C1);
  - beats_for(cmd) function.
- Shared with the cache model and bench.
- Single module; the timeout counter is inline (no sub-module).

Test Plan:
- RD16 addr 18'h0ABC5, bench responds C1=7 with D1=16'hBEEF on first WAIT edge -> CMD1 a1=14'h0ABC, c1=2; CMD2 a1=5; resp_rdata=32'h0000BEEF; resp_valid 4 cycles after acceptance.
- WR32 wdata 32'h12345678 -> CMD1 d1_out=16'h5678, CMD2 d1_out=16'h1234, TURN all oe=0; response beat -> resp_valid, rdata=0, err=0.
- RD32 beats 16'h1111 then (after 3 idle cycles) 16'h2222 -> rdata=32'h22221111; response held 4 cycles in RELEASE does not start another beat count.
- No response after RD8 -> resp_err=1, rdata=0 exactly TIMEOUT_CYCLES-1 cycles after WAIT entry; req_ready back to 1.
- rst_n low during WAIT -> all oe=0 immediately, no resp_valid, req_count=0; next request proceeds normally.
- Back-to-back NOP then INVAL -> NOP resp_valid next cycle with no bus drive; INVAL drives c1=4, completes on one beat; req_count=2.
